// File: rtl/sd_ext_wb_master_pkg.sv
// Shared definitions for the SD external-side Wishbone block mover:
// block geometry, FSM state encoding and word/address helpers.
package sd_ext_wb_master_pkg;

   localparam int SD_BLK_WORDS = 128;
   localparam int SD_BLK_SHIFT = 9;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_BEAT  = 3'd1,
      S_RD_GO    = 3'd2,
      S_WR_FETCH = 3'd3,
      S_WR_BEAT  = 3'd4,
      S_WR_DONE  = 3'd5
   } sd_state_e;

   function automatic logic [31:0] byte_swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   // Byte address of word idx of block blk; the sum wraps modulo 2^32.
   function automatic logic [31:0] beat_adr(input logic [31:0] base,
                                            input logic [22:0] blk,
                                            input logic [6:0]  idx);
      return base + (32'(blk) << SD_BLK_SHIFT) + 32'({idx, 2'b00});
   endfunction

endpackage

// File: rtl/sd_ext_wb_master_if.sv
// Wishbone classic bus bundle between the SD block mover (master) and the
// system bus (slave).
interface sd_ext_wb_master_if;

   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );

endinterface

// File: rtl/sd_ext_wb_master_sync2.sv
// Two-flop synchroniser for level handshake inputs coming from the SD manager.
module sd_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Double-register the asynchronous level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/sd_ext_wb_master.sv
// Wishbone classic master answering the SD manager's block read/write
// handshakes: moves one 128-word block between bus memory and the BRAM ports.
module sd_ext_wb_master
   import sd_ext_wb_master_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          TIMEOUT_CYC = 1024,
   parameter bit          BYTE_SWAP   = 1'b0
) (
   input  logic                 i_clk_50,
   input  logic                 i_reset,
   input  logic                 i_ext_read_act,
   output logic                 o_ext_read_go,
   input  logic [31:0]          i_ext_read_addr,
   input  logic                 i_ext_read_stop,
   input  logic                 i_ext_write_act,
   output logic                 o_ext_write_done,
   input  logic [31:0]          i_ext_write_addr,
   output logic [6:0]           o_bram_rd_ext_addr,
   output logic                 o_bram_rd_ext_wren,
   output logic [31:0]          o_bram_rd_ext_data,
   output logic [6:0]           o_bram_wr_ext_addr,
   input  logic [31:0]          i_bram_wr_ext_q,
   sd_ext_wb_master_if.master   wb,
   output logic                 o_xfer_err
);

   localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [6:0]       LAST_BEAT = 7'(SD_BLK_WORDS - 1);

   logic w_rd_act;
   logic w_rd_stop;
   logic w_wr_act;
   logic w_beat_err;
   logic w_beat_end;
   logic [31:0] w_rx_data;
   logic [31:0] w_tx_data;
   logic w_unused;

   sd_state_e        r_state;
   logic [22:0]      r_blk;
   logic [6:0]       r_i;
   logic [TMO_W-1:0] r_tmo;
   logic             r_cyc;
   logic             r_stb;
   logic             r_we;
   logic [31:0]      r_adr;
   logic [31:0]      r_dat;
   logic             r_rd_go;
   logic             r_wr_done;
   logic             r_rd_wren;
   logic [6:0]       r_rd_addr;
   logic [31:0]      r_rd_data;
   logic [6:0]       r_wr_addr;
   logic             r_xfer_err;

   sd_sync2 u_sync_rd_act  (.i_clk(i_clk_50), .i_rst(i_reset), .i_d(i_ext_read_act),  .o_q(w_rd_act));
   sd_sync2 u_sync_rd_stop (.i_clk(i_clk_50), .i_rst(i_reset), .i_d(i_ext_read_stop), .o_q(w_rd_stop));
   sd_sync2 u_sync_wr_act  (.i_clk(i_clk_50), .i_rst(i_reset), .i_d(i_ext_write_act), .o_q(w_wr_act));

   // An ack coinciding with err, or the last timeout cycle, ends the beat as an error.
   assign w_beat_err = wb.wb_err_i | (r_tmo == TMO_LAST);
   assign w_beat_end = wb.wb_ack_i | w_beat_err;
   assign w_rx_data  = BYTE_SWAP ? byte_swap32(wb.wb_dat_i) : wb.wb_dat_i;
   assign w_tx_data  = BYTE_SWAP ? byte_swap32(i_bram_wr_ext_q) : i_bram_wr_ext_q;
   assign w_unused   = ^{i_ext_read_addr[31:23], i_ext_write_addr[31:23]};

   // Block transfer sequencer with all bus, BRAM and handshake outputs registered.
   always_ff @(posedge i_clk_50 or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_blk      <= 23'd0;
         r_i        <= 7'd0;
         r_tmo      <= '0;
         r_cyc      <= 1'b0;
         r_stb      <= 1'b0;
         r_we       <= 1'b0;
         r_adr      <= 32'd0;
         r_dat      <= 32'd0;
         r_rd_go    <= 1'b0;
         r_wr_done  <= 1'b0;
         r_rd_wren  <= 1'b0;
         r_rd_addr  <= 7'd0;
         r_rd_data  <= 32'd0;
         r_wr_addr  <= 7'd0;
         r_xfer_err <= 1'b0;
      end else begin
         r_rd_wren <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cyc <= 1'b0;
               r_stb <= 1'b0;
               r_we  <= 1'b0;
               // A read request is ignored while the previous go is still being stopped.
               if (w_rd_act && !w_rd_stop) begin
                  r_blk      <= i_ext_read_addr[22:0];
                  r_i        <= 7'd0;
                  r_xfer_err <= 1'b0;
                  r_state    <= S_RD_BEAT;
               end else if (w_wr_act) begin
                  r_blk      <= i_ext_write_addr[22:0];
                  r_i        <= 7'd0;
                  r_wr_addr  <= 7'd0;
                  r_xfer_err <= 1'b0;
                  r_state    <= S_WR_FETCH;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RD_BEAT: begin
               if (!r_stb) begin
                  r_adr <= beat_adr(BASE_ADDR, r_blk, r_i);
                  r_cyc <= 1'b1;
                  r_stb <= 1'b1;
                  r_tmo <= '0;
               end else if (w_beat_end) begin
                  r_cyc      <= 1'b0;
                  r_stb      <= 1'b0;
                  r_rd_wren  <= 1'b1;
                  r_rd_addr  <= r_i;
                  r_rd_data  <= w_beat_err ? 32'd0 : w_rx_data;
                  r_xfer_err <= r_xfer_err | w_beat_err;
                  r_i        <= r_i + 7'd1;
                  if (r_i == LAST_BEAT) begin
                     r_rd_go <= w_rd_act;
                     r_state <= w_rd_act ? S_RD_GO : S_IDLE;
                  end else begin
                     r_state <= S_RD_BEAT;
                  end
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            S_RD_GO: begin
               if (w_rd_stop) begin
                  r_rd_go <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_RD_GO;
               end
            end
            S_WR_FETCH: begin
               r_state <= S_WR_BEAT;
            end
            S_WR_BEAT: begin
               // First cycle here captures the BRAM word fetched for beat i.
               if (!r_stb) begin
                  r_adr <= beat_adr(BASE_ADDR, r_blk, r_i);
                  r_dat <= w_tx_data;
                  r_cyc <= 1'b1;
                  r_stb <= 1'b1;
                  r_we  <= 1'b1;
                  r_tmo <= '0;
               end else if (w_beat_end) begin
                  r_cyc      <= 1'b0;
                  r_stb      <= 1'b0;
                  r_we       <= 1'b0;
                  r_xfer_err <= r_xfer_err | w_beat_err;
                  r_i        <= r_i + 7'd1;
                  r_wr_addr  <= r_i + 7'd1;
                  if (r_i == LAST_BEAT) begin
                     r_wr_done <= w_wr_act;
                     r_state   <= w_wr_act ? S_WR_DONE : S_IDLE;
                  end else begin
                     r_state <= S_WR_FETCH;
                  end
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            S_WR_DONE: begin
               if (!w_wr_act) begin
                  r_wr_done <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_state <= S_WR_DONE;
               end
            end
            default: begin
               r_cyc   <= 1'b0;
               r_stb   <= 1'b0;
               r_we    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_ext_read_go      = r_rd_go;
   assign o_ext_write_done   = r_wr_done;
   assign o_bram_rd_ext_addr = r_rd_addr;
   assign o_bram_rd_ext_wren = r_rd_wren;
   assign o_bram_rd_ext_data = r_rd_data;
   assign o_bram_wr_ext_addr = r_wr_addr;
   assign o_xfer_err         = r_xfer_err;
   assign wb.wb_adr_o        = r_adr;
   assign wb.wb_dat_o        = r_dat;
   assign wb.wb_we_o         = r_we;
   assign wb.wb_sel_o        = 4'hF;
   assign wb.wb_cyc_o        = r_cyc;
   assign wb.wb_stb_o        = r_stb;

endmodule

// File: tb/tb_sd_ext_wb_master.sv
// Self-checking bench for sd_ext_wb_master: randomised Wishbone slave and
// BRAM models, with block-level expectations computed from address arithmetic.
module tb_sd_ext_wb_master;

   localparam logic [31:0] BASE = 32'h0000_0200;
   localparam int          TMO  = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_act = 1'b0, rd_stop = 1'b0, wr_act = 1'b0;
   logic [31:0] rd_addr = 32'd0, wr_addr = 32'd0;
   logic        rd_go, wr_done, bram_rd_wren, xfer_err;
   logic [6:0]  bram_rd_addr, bram_wr_addr;
   logic [31:0] bram_rd_data, wr_q;

   sd_ext_wb_master_if wbif ();

   sd_ext_wb_master #(.BASE_ADDR(BASE), .TIMEOUT_CYC(TMO), .BYTE_SWAP(1'b1)) dut (
      .i_clk_50(clk), .i_reset(rst),
      .i_ext_read_act(rd_act), .o_ext_read_go(rd_go), .i_ext_read_addr(rd_addr),
      .i_ext_read_stop(rd_stop),
      .i_ext_write_act(wr_act), .o_ext_write_done(wr_done), .i_ext_write_addr(wr_addr),
      .o_bram_rd_ext_addr(bram_rd_addr), .o_bram_rd_ext_wren(bram_rd_wren),
      .o_bram_rd_ext_data(bram_rd_data),
      .o_bram_wr_ext_addr(bram_wr_addr), .i_bram_wr_ext_q(wr_q),
      .wb(wbif.master), .o_xfer_err(xfer_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Slave / memory model state
   int          slv_mode = 0;   // 0 normal, 1 error on err_beat, 2 never respond
   int          err_beat = -1;
   int          lat = 0, wcnt = 0, beat_cnt = 0, run = 0, n_wren = 0;
   logic [31:0] rd_seed = 32'd0;
   logic        force_en = 1'b0;
   logic [31:0] force_adr = 32'd0, force_val = 32'd0;
   logic [31:0] q_adr[$], q_dat[$];
   logic        q_we[$];
   logic [3:0]  q_sel[$];
   int          q_run[$];
   logic [31:0] rd_bram[128];
   logic [31:0] wr_bram[128];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (force_en && a == force_adr) return force_val;
      return (a * 32'h9E37_79B1) ^ rd_seed;
   endfunction

   function automatic logic [31:0] swap_model(input logic [31:0] x);
      return ((x >> 24) & 32'h0000_00FF) | ((x >> 8) & 32'h0000_FF00) |
             ((x << 8) & 32'h00FF_0000) | (x << 24);
   endfunction

   function automatic logic [31:0] exp_adr(input logic [31:0] blk, input int k);
      logic [31:0] off;
      off = blk * 32'd512;
      return BASE + off + 32'(k * 4);
   endfunction

   // Wishbone slave: logs each beat at strobe start, answers after a random wait.
   always @(negedge clk) begin
      if (rst) begin
         wbif.wb_ack_i = 1'b0;
         wbif.wb_err_i = 1'b0;
         wbif.wb_dat_i = 32'd0;
         wcnt = 0;
         run  = 0;
      end else begin
         wbif.wb_ack_i = 1'b0;
         wbif.wb_err_i = 1'b0;
         if (wbif.wb_cyc_o && wbif.wb_stb_o) begin
            if (run == 0) begin
               q_adr.push_back(wbif.wb_adr_o);
               q_dat.push_back(wbif.wb_dat_o);
               q_we.push_back(wbif.wb_we_o);
               q_sel.push_back(wbif.wb_sel_o);
            end
            run++;
            if (slv_mode != 2 && wcnt >= lat) begin
               wbif.wb_ack_i = 1'b1;
               if (slv_mode == 1 && beat_cnt == err_beat) wbif.wb_err_i = 1'b1;
               wbif.wb_dat_i = mem_word(wbif.wb_adr_o);
               beat_cnt++;
               wcnt = 0;
               lat  = $urandom_range(0, 3);
            end else begin
               wcnt++;
            end
         end else begin
            if (run != 0) q_run.push_back(run);
            run  = 0;
            wcnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bram_rd_wren) begin
         rd_bram[bram_rd_addr] = bram_rd_data;
         n_wren++;
      end
   end

   always @(posedge clk) wr_q <= wr_bram[bram_wr_addr];

   task automatic clear_log();
      q_adr.delete(); q_dat.delete(); q_we.delete(); q_sel.delete(); q_run.delete();
      beat_cnt = 0;
      n_wren   = 0;
      for (int k = 0; k < 128; k++) rd_bram[k] = 32'hDEAD_BEEF;
   endtask

   task automatic wait_go();
      int c = 0;
      while (!rd_go && c < 5000) begin @(negedge clk); c++; end
      #1;
      check_eq("rd_go_rise", rd_go, 1'b1);
   endtask

   task automatic read_stop();
      int c = 0;
      @(negedge clk);
      rd_act  = 1'b0;
      rd_stop = 1'b1;
      while (rd_go && c < 10) begin @(negedge clk); c++; end
      check_eq("rd_go_fall_within_3", (!rd_go && c <= 3), 1'b1);
      rd_stop = 1'b0;
   endtask

   task automatic check_read(input logic [31:0] blk, input int mode, input int ebeat);
      int nbad = 0;
      logic [31:0] a, e;
      check_eq("rd_wren_cnt", n_wren, 128);
      check_eq("rd_beats", q_adr.size(), 128);
      for (int k = 0; k < 128; k++) begin
         a = exp_adr(blk, k);
         if (k < q_adr.size()) begin
            if (q_adr[k] !== a || q_we[k] !== 1'b0 || q_sel[k] !== 4'hF) nbad++;
         end
         e = (mode == 2 || (mode == 1 && k == ebeat)) ? 32'd0 : swap_model(mem_word(a));
         if (rd_bram[k] !== e) nbad++;
      end
      check_eq("rd_block_bad", nbad, 0);
      check_eq("rd_xfer_err", xfer_err, (mode != 0));
   endtask

   task automatic read_block(input logic [31:0] blk, input int mode, input int ebeat);
      slv_mode = mode;
      err_beat = ebeat;
      clear_log();
      @(negedge clk);
      rd_addr = blk;
      rd_act  = 1'b1;
      wait_go();
      check_read(blk, mode, ebeat);
      read_stop();
      repeat (4) @(negedge clk);
   endtask

   task automatic fill_wr_bram();
      for (int k = 0; k < 128; k++) wr_bram[k] = $urandom;
   endtask

   task automatic finish_write(input logic [31:0] blk);
      int c = 0;
      int nbad = 0;
      while (!wr_done && c < 5000) begin @(negedge clk); c++; end
      #1;
      check_eq("wr_done_rise", wr_done, 1'b1);
      check_eq("wr_beats", q_adr.size(), 128);
      for (int k = 0; k < 128 && k < q_adr.size(); k++) begin
         if (q_adr[k] !== exp_adr(blk, k) || q_we[k] !== 1'b1 || q_sel[k] !== 4'hF ||
             q_dat[k] !== swap_model(wr_bram[k])) nbad++;
      end
      check_eq("wr_block_bad", nbad, 0);
      check_eq("wr_xfer_err", xfer_err, 1'b0);
      @(negedge clk);
      wr_act = 1'b0;
      c = 0;
      while (wr_done && c < 10) begin @(negedge clk); c++; end
      check_eq("wr_done_fall", (!wr_done && c <= 3), 1'b1);
      repeat (4) @(negedge clk);
   endtask

   task automatic write_block(input logic [31:0] blk);
      slv_mode = 0;
      clear_log();
      fill_wr_bram();
      @(negedge clk);
      check_eq("wr_done_low_at_start", wr_done, 1'b0);
      wr_addr = blk;
      wr_act  = 1'b1;
      finish_write(blk);
   endtask

   initial begin
      int c;
      int nbad;
      logic [31:0] b1, b2;
      rd_seed = $urandom;
      repeat (3) @(negedge clk);
      check_eq("rst_outputs", {rd_go, wr_done, bram_rd_wren, xfer_err, wbif.wb_cyc_o,
                               wbif.wb_stb_o, wbif.wb_we_o}, 32'd0);
      check_eq("rst_adr", wbif.wb_adr_o, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed: plain read of block 5, then write of block 2.
      read_block(32'd5, 0, -1);
      write_block(32'd2);

      // Slave errors (ack+err together) on beat 10.
      read_block(32'd77, 1, 10);

      // Slave never responds: every beat times out after TMO cycles.
      read_block(32'd9, 2, -1);
      nbad = 0;
      foreach (q_run[k]) if (q_run[k] != TMO) nbad++;
      check_eq("tmo_runs", q_run.size(), 128);
      check_eq("tmo_run_len_bad", nbad, 0);

      // Next read after error must start with xfer_err cleared.
      read_block(32'd10, 0, -1);

      // Byte swap of a known word, and block/base address wrap to 0.
      force_en  = 1'b1;
      force_adr = 32'h0000_0000;
      force_val = 32'h1122_3344;
      read_block(32'hFFFF_FFFF, 0, -1);
      check_eq("wrap_adr0", (q_adr.size() > 0) ? q_adr[0] : 32'hFFFF_FFFF, 32'h0000_0000);
      check_eq("swap_word0", rd_bram[0], 32'h4433_2211);
      force_en = 1'b0;

      // Read act dropped mid-block: block completes without go.
      slv_mode = 0;
      clear_log();
      @(negedge clk);
      rd_addr = 32'd33;
      rd_act  = 1'b1;
      c = 0;
      while (q_adr.size() < 64 && c < 5000) begin @(negedge clk); c++; end
      rd_act = 1'b0;
      c = 0;
      while (n_wren < 128 && c < 5000) begin @(negedge clk); c++; end
      repeat (6) @(negedge clk);
      check_eq("rd_drop_no_go", rd_go, 1'b0);
      check_read(32'd33, 0, -1);

      // Read and write requested together: read served first, then write.
      b1 = $urandom;
      b2 = $urandom;
      clear_log();
      fill_wr_bram();
      @(negedge clk);
      rd_addr = b1;
      wr_addr = b2;
      rd_act  = 1'b1;
      wr_act  = 1'b1;
      wait_go();
      check_read(b1, 0, -1);
      read_stop();
      clear_log();
      finish_write(b2);

      // Async reset during beat 60 of a write; the next write restarts at word 0.
      slv_mode = 0;
      clear_log();
      fill_wr_bram();
      @(negedge clk);
      wr_addr = 32'd4;
      wr_act  = 1'b1;
      c = 0;
      while (q_adr.size() < 61 && c < 5000) begin @(negedge clk); c++; end
      check_eq("rst_mid_stb_high", wbif.wb_stb_o, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_bus", {wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_we_o, wr_done}, 32'd0);
      wr_act = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      write_block(32'd6);

      // Randomised block mix.
      for (int it = 0; it < 4; it++) begin
         if ($urandom_range(0, 1) == 1) read_block($urandom, 0, -1);
         else write_block($urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
